// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer for the RV32I core.
// Walks one instruction at a time through FETCH/DECODE/EXEC/(MEM)/WB,
// handshakes with instruction and data memory, gates decoder enables,
// halts on illegal opcodes or memory timeouts, and counts retirements.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for i_start
// FETCH  | instruction fetch, waits for i_imem_ready (bounded)
// DECODE | opcode legality check
// EXEC   | ALU cycle; loads/stores go on to MEM
// MEM    | data access, waits for i_dmem_ready (bounded)
// WB     | register write-back, PC update, retire
// HALT   | illegal opcode or memory timeout; left only through reset
module multicycle_sequencer #(
   parameter int CNT_BITS    = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic [6:0]          i_opcode,
   input  logic                i_dec_wEn,
   input  logic                i_dec_mem_wEn,
   input  logic                i_imem_ready,
   input  logic                i_dmem_ready,
   output logic                o_imem_req,
   output logic                o_ir_load,
   output logic                o_dmem_req,
   output logic                o_dmem_we,
   output logic                o_rf_wEn,
   output logic                o_pc_en,
   output logic [2:0]          o_state,
   output logic                o_halted,
   output logic                o_timeout_err,
   output logic [CNT_BITS-1:0] o_instret
);

   localparam int WAIT_BITS = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;
   localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [WAIT_BITS-1:0]  r_wait_cnt;
   logic                  r_timeout_err;
   logic [CNT_BITS-1:0]   r_instret;
   logic                  w_legal;
   logic                  w_is_mem;
   logic                  w_waiting;
   logic                  w_ready;
   logic                  w_timeout;

   // Opcode classification: legal RV32I major opcodes and load/store detection.
   always_comb begin
      w_legal = 1'b0;
      case (i_opcode)
         7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011, 7'b1100011,
         7'b1100111, 7'b1101111, 7'b0010111, 7'b0110111: w_legal = 1'b1;
         default:                                        w_legal = 1'b0;
      endcase
      w_is_mem = (i_opcode == 7'b0000011) || (i_opcode == 7'b0100011);
   end

   // Memory wait tracking; a ready on the final allowed cycle still completes the access.
   assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM);
   assign w_ready   = (r_state == S_FETCH) ? i_imem_ready : i_dmem_ready;
   assign w_timeout = w_waiting && !w_ready && (r_wait_cnt == WAIT_LAST);

   // State register.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next-state and output decode from the registered state.
   always_comb begin
      w_next     = r_state;
      o_imem_req = 1'b0;
      o_ir_load  = 1'b0;
      o_dmem_req = 1'b0;
      o_dmem_we  = 1'b0;
      o_rf_wEn   = 1'b0;
      o_pc_en    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_next = S_FETCH;
         end
         S_FETCH: begin
            o_imem_req = 1'b1;
            if (i_imem_ready) begin
               o_ir_load = 1'b1;
               w_next    = S_DECODE;
            end else if (w_timeout) begin
               w_next = S_HALT;
            end
         end
         S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
         S_EXEC:   w_next = w_is_mem ? S_MEM : S_WB;
         S_MEM: begin
            o_dmem_req = 1'b1;
            o_dmem_we  = i_dec_mem_wEn;
            if (i_dmem_ready)   w_next = S_WB;
            else if (w_timeout) w_next = S_HALT;
         end
         S_WB: begin
            o_rf_wEn = i_dec_wEn;
            o_pc_en  = 1'b1;
            w_next   = S_FETCH;
         end
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_HALT;
      endcase
   end

   // Wait counter: held at zero outside the request states, so it is clear on entry.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset)         r_wait_cnt <= '0;
      else if (!w_waiting) r_wait_cnt <= '0;
      else if (!w_ready)   r_wait_cnt <= r_wait_cnt + 1'b1;
   end

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset)        r_timeout_err <= 1'b0;
      else if (w_timeout) r_timeout_err <= 1'b1;
   end

   // Retired-instruction counter; wraps silently.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset)              r_instret <= '0;
      else if (r_state == S_WB) r_instret <= r_instret + 1'b1;
   end

   assign o_state       = r_state;
   assign o_halted      = (r_state == S_HALT);
   assign o_timeout_err = r_timeout_err;
   assign o_instret     = r_instret;

endmodule
